mem_port_arbiter: RTL

Arbiter that shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the five-stage pipeline. It accepts one transaction at a time, drives the memory port through a ready handshake, and returns read data or a store acknowledge to the winning stage. It also produces per-stage stall signals for the hazard logic.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data stage. One transaction in flight at a time. Data requests win
// by fixed priority. Defining ARB_STARVE_GUARD_EN adds a counter that hands
// the port to fetch after MAX_WAIT back-to-back data grants made while fetch
// was waiting.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,        // synchronous, active-low
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;
    logic          if_gnt_c, dm_gnt_c;
    logic          fetch_first;   // starvation guard overrides data priority

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    assign fetch_first = (wait_cnt_q == CW'(MAX_WAIT));

    // Count data grants that bypassed a waiting fetch; any other grant clears.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (if_gnt_c) begin
            wait_cnt_d = '0;
        end else if (dm_gnt_c) begin
            wait_cnt_d = if_req ? wait_cnt_q + CW'(1) : '0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (!rst) wait_cnt_q <= '0;
        else      wait_cnt_q <= wait_cnt_d;
    end
`else
    // Guard compiled out: data always wins and MAX_WAIT has no effect.
    assign fetch_first = (MAX_WAIT < 0);
`endif

    // Arbitration, memory-port sequencing and completion handling.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_gnt_c    = 1'b0;
        dm_gnt_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req && (!dm_req || fetch_first)) begin
                    if_gnt_c   = 1'b1;
                    state_d    = BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end else if (dm_req) begin
                    dm_gnt_c    = 1'b1;
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    // A store only acknowledges; load data stays untouched.
                    if (!mem_we_q) dm_rdata_d = mem_rdata;
                    dm_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the address/data registers are reset too, because
            // downstream logic observes them as zero straight after reset.
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    // Grants and stalls are combinational; all are held low while in reset.
    assign if_gnt    = rst & if_gnt_c;
    assign dm_gnt    = rst & dm_gnt_c;
    assign stall_if  = rst & if_req & ~if_valid_q;
    assign stall_mem = rst & dm_req & ~dm_valid_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;

endmodule
